// File: rtl/mem_bus_ctrl_if.sv
// Core-side request/response handshake bundle for mem_bus_ctrl.
// master = core (issues requests, consumes responses), slave = controller.
`timescale 1ns/1ps

interface mem_bus_ctrl_if #(
    parameter int DWIDTH = 16,
    parameter int AWIDTH = 8
);
    logic              reqValid;
    logic              reqReady;
    logic              reqWe;
    logic [AWIDTH-1:0] reqAddr;
    logic [DWIDTH-1:0] reqWdata;
    logic              respValid;
    logic [DWIDTH-1:0] respRdata;
    logic              respErr;

    modport master (
        output reqValid, reqWe, reqAddr, reqWdata,
        input  reqReady, respValid, respRdata, respErr
    );

    modport slave (
        input  reqValid, reqWe, reqAddr, reqWdata,
        output reqReady, respValid, respRdata, respErr
    );
endinterface

// File: rtl/mem_bus_ctrl.sv
// Request-side controller for the single-port data RAM: takes one load or
// store at a time from the core (bus), sequences memAddr/memRdEn/memWrEn,
// owns the shared memData tristate bus and returns a one-cycle response.
// Ports: clk, reset (sync, active-high), bus (slave handshake),
//        memData (inout), memAddr, memRdEn, memWrEn.
`timescale 1ns/1ps

module mem_bus_ctrl #(
    parameter int DWIDTH   = 16,
    parameter int AWIDTH   = 8,
    parameter int MEMDEPTH = 256
) (
    input  logic              clk,
    input  logic              reset,
    mem_bus_ctrl_if.slave     bus,
    inout  wire  [DWIDTH-1:0] memData,
    output logic [AWIDTH-1:0] memAddr,
    output logic              memRdEn,
    output logic              memWrEn
);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WR,
        TURN,
        RESP
    } state_t;

    state_t            state;
    logic              readyQ;
    logic              rdEnQ;
    logic              wrEnQ;
    logic [DWIDTH-1:0] wdataQ;
    logic              respValidQ;
    logic [DWIDTH-1:0] respRdataQ;
    logic              respErrQ;
    logic              drive;
    logic              outOfRange;

    // 33-bit compare so MEMDEPTH == 2**AWIDTH leaves every address legal.
    localparam logic [32:0] DEPTH = 33'(MEMDEPTH);
    assign outOfRange = 33'(bus.reqAddr) >= DEPTH;

    // Enables are gated by reset so no RAM write can commit on a reset edge.
    assign bus.reqReady  = readyQ & ~reset;
    assign memRdEn       = rdEnQ & ~reset;
    assign memWrEn       = wrEnQ & ~reset;
    assign bus.respValid = respValidQ;
    assign bus.respRdata = respRdataQ;
    assign bus.respErr   = respErrQ;

    // The controller drives the RAM bus only during the WR cycle.
    assign drive   = (state == WR);
    assign memData = drive ? wdataQ : 'z;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            readyQ     <= 1'b1;
            memAddr    <= '0;
            rdEnQ      <= 1'b0;
            wrEnQ      <= 1'b0;
            wdataQ     <= '0;
            respValidQ <= 1'b0;
            respRdataQ <= '0;
            respErrQ   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.reqValid && readyQ) begin
                        readyQ <= 1'b0;
                        wdataQ <= bus.reqWdata;
                        if (outOfRange) begin
                            state      <= RESP;
                            respValidQ <= 1'b1;
                            respErrQ   <= 1'b1;
                            respRdataQ <= '0;
                        end else if (bus.reqWe) begin
                            state   <= WR;
                            memAddr <= bus.reqAddr;
                            wrEnQ   <= 1'b1;
                        end else begin
                            state   <= RD;
                            memAddr <= bus.reqAddr;
                            rdEnQ   <= 1'b1;
                        end
                    end
                end
                RD: begin
                    rdEnQ      <= 1'b0;
                    respRdataQ <= memData;
                    respErrQ   <= 1'b0;
                    respValidQ <= 1'b1;
                    state      <= RESP;
                end
                WR: begin
                    // Bus released next cycle (TURN) before anyone else drives.
                    wrEnQ <= 1'b0;
                    state <= TURN;
                end
                TURN: begin
                    respRdataQ <= '0;
                    respErrQ   <= 1'b0;
                    respValidQ <= 1'b1;
                    state      <= RESP;
                end
                RESP: begin
                    respValidQ <= 1'b0;
                    respRdataQ <= '0;
                    respErrQ   <= 1'b0;
                    readyQ     <= 1'b1;
                    state      <= IDLE;
                end
                default: begin
                    state  <= IDLE;
                    readyQ <= 1'b1;
                    rdEnQ  <= 1'b0;
                    wrEnQ  <= 1'b0;
                end
            endcase
        end
    end

    a_en_excl: assert property (
        @(posedge clk) disable iff (reset) !(memRdEn && memWrEn));
    a_drive_wr: assert property (
        @(posedge clk) disable iff (reset) drive |-> memWrEn);
    a_no_drive_rd: assert property (
        @(posedge clk) disable iff (reset) !(drive && memRdEn));

endmodule
